rgb_pwm_fader: RTL and testbench

- Generates the three PWM drive signals (red, green, blue) that feed the RGB LED hard driver's PWM inputs. Sits directly upstream of that driver.
- Accepts a target colour (three 8-bit duties) over a valid/ready handshake.
- Either jumps to the new colour or ramps each channel linearly toward it.
- Duty changes take effect only on PWM period boundaries, so outputs never glitch mid-period.

---
 rtl/rgb_pwm_fader_if.sv | 28 ++
 rtl/rgb_pwm_fader.sv | 122 ++++++++++++
 tb/tb_rgb_pwm_fader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pwm_fader_if.sv
// Target-colour handshake between a colour source and rgb_pwm_fader.
// The source offers three 8-bit duties plus a fade/jump select under valid/ready.
interface rgb_pwm_fader_if;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [7:0] tgt_red;
  logic [7:0] tgt_green;
  logic [7:0] tgt_blue;
  logic       fade_en;

  modport master (
    output tgt_valid,
    output tgt_red,
    output tgt_green,
    output tgt_blue,
    output fade_en,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_red,
    input  tgt_green,
    input  tgt_blue,
    input  fade_en,
    output tgt_ready
  );
endinterface

// File: rtl/rgb_pwm_fader.sv
// Three-channel 8-bit PWM generator for the RGB LED driver that either jumps or linearly fades
// to a new colour; duty registers only ever change on a PWM period boundary.
module rgb_pwm_fader #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned FADE_DIV = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  rgb_pwm_fader_if.slave tgt,
  output logic           busy_o,
  output logic           period_start_o,
  output logic           red_pwm_o,
  output logic           green_pwm_o,
  output logic           blue_pwm_o
);

  localparam int unsigned PsW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DivW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PsW-1:0]  PsMax  = PsW'(PRESCALE - 1);
  localparam logic [DivW-1:0] DivMax = DivW'(FADE_DIV - 1);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e          state_q;
  logic            mode_q;
  logic [PsW-1:0]  presc_q;
  logic [7:0]      cnt_q;
  logic [DivW-1:0] div_q;
  logic            ps_q;
  logic [2:0]      pwm_q;
  // Channel index 0 = red, 1 = green, 2 = blue.
  logic [2:0][7:0] duty_q;
  logic [2:0][7:0] tgt_q;
  logic [2:0][7:0] step_d;

  logic tick, bnd, step_now, accept, at_tgt;

  assign tick          = (presc_q == PsMax);
  assign bnd           = tick && (cnt_q == 8'hff);
  assign step_now      = bnd && (div_q == DivMax);
  assign tgt.tgt_ready = (state_q == StIdle);
  assign accept        = tgt.tgt_valid && tgt.tgt_ready;

  // One saturating-by-construction step toward the target on each fade step.
  always_comb begin
    step_d = duty_q;
    for (int i = 0; i < 3; i++) begin
      if (step_now && (duty_q[i] < tgt_q[i])) begin
        step_d[i] = duty_q[i] + 8'd1;
      end else if (step_now && (duty_q[i] > tgt_q[i])) begin
        step_d[i] = duty_q[i] - 8'd1;
      end
    end
  end

  assign at_tgt = (step_d == tgt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      ps_q    <= 1'b0;
      pwm_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        cnt_q <= cnt_q + 8'd1;
      end
      ps_q <= bnd;
      for (int i = 0; i < 3; i++) begin
        pwm_q[i] <= (cnt_q < duty_q[i]);
      end
      // An accept coinciding with a boundary wins: that boundary is not counted.
      if (accept) begin
        div_q <= '0;
      end else if (bnd) begin
        div_q <= (div_q == DivMax) ? '0 : div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      tgt_q   <= '0;
      duty_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            tgt_q   <= {tgt.tgt_blue, tgt.tgt_green, tgt.tgt_red};
            mode_q  <= tgt.fade_en;
            state_q <= StXfer;
          end
        end
        StXfer: begin
          if (bnd) begin
            if (!mode_q) begin
              duty_q  <= tgt_q;
              state_q <= StIdle;
            end else begin
              duty_q <= step_d;
              if (at_tgt) begin
                state_q <= StIdle;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o         = ~tgt.tgt_ready;
  assign period_start_o = ps_q;
  assign red_pwm_o      = pwm_q[0];
  assign green_pwm_o    = pwm_q[1];
  assign blue_pwm_o     = pwm_q[2];

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: three parameterisations share one directed stimulus, each checked
// every cycle against an arithmetic model, with literal pulse-width checks on the first.
module tb_rgb_pwm_fader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid = 1'b0;
  logic [7:0] s_r = '0;
  logic [7:0] s_g = '0;
  logic [7:0] s_b = '0;
  logic       s_fade = 1'b0;

  int total = 0;
  int bad   = 0;
  int mr [16];
  int mg [16];
  int mb [16];

  always #5 clk = ~clk;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t: got %0d want %0d", name, inst, $time, act, exp);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : u
    localparam int P  = (k == 2) ? 3 : 1;
    localparam int FD = (k == 0) ? 2 : 1;

    rgb_pwm_fader_if bus ();
    logic busy, ps, red, green, blue;

    assign bus.tgt_valid = s_valid;
    assign bus.tgt_red   = s_r;
    assign bus.tgt_green = s_g;
    assign bus.tgt_blue  = s_b;
    assign bus.fade_en   = s_fade;

    rgb_pwm_fader #(.PRESCALE(P), .FADE_DIV(FD)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tgt           (bus),
      .busy_o        (busy),
      .period_start_o(ps),
      .red_pwm_o     (red),
      .green_pwm_o   (green),
      .blue_pwm_o    (blue)
    );

    // Model: time since reset release fixes the counter phase; duties follow the transfer rules.
    int   c = 0;
    int   nb = 0;
    int   acc = 0;
    int   d [3] = '{0, 0, 0};
    int   t [3] = '{0, 0, 0};
    bit   m_busy = 1'b0;
    bit   m_fade = 1'b0;
    logic [2:0] e_pwm = '0;
    logic e_ps = 1'b0;

    initial forever begin
      bit b;
      int cnt;
      bit done;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        c = 0; nb = 0; m_busy = 0; m_fade = 0; e_pwm = '0; e_ps = 0;
        for (int i = 0; i < 3; i++) begin d[i] = 0; t[i] = 0; end
      end else begin
        b   = (c % (256 * P)) == (256 * P - 1);
        cnt = (c / P) % 256;
        for (int i = 0; i < 3; i++) e_pwm[i] = (cnt < d[i]);
        e_ps = b;
        if (!m_busy) begin
          if (s_valid) begin
            t[0] = int'(s_r); t[1] = int'(s_g); t[2] = int'(s_b);
            m_fade = s_fade; m_busy = 1; nb = 0; acc++;
          end
        end else if (b) begin
          nb++;
          if (!m_fade) begin
            for (int i = 0; i < 3; i++) d[i] = t[i];
            m_busy = 0;
          end else begin
            if (nb % FD == 0) begin
              for (int i = 0; i < 3; i++) begin
                if (d[i] < t[i]) d[i]++;
                else if (d[i] > t[i]) d[i]--;
              end
            end
            done = 1;
            for (int i = 0; i < 3; i++) if (d[i] != t[i]) done = 0;
            if (done) m_busy = 0;
          end
        end
        c++;
      end
    end

    initial forever begin
      @(negedge clk);
      check("red_pwm", k, red, e_pwm[0]);
      check("green_pwm", k, green, e_pwm[1]);
      check("blue_pwm", k, blue, e_pwm[2]);
      check("period_start", k, ps, e_ps);
      check("tgt_ready", k, bus.tgt_ready, !m_busy);
      check("busy", k, busy, m_busy);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Holds valid until every instance has taken the offer; leaves valid asserted.
  task automatic present(input logic [7:0] rv, input logic [7:0] gv, input logic [7:0] bv,
                         input logic fv);
    int a0, a1, a2, n;
    @(negedge clk);
    s_r = rv; s_g = gv; s_b = bv; s_fade = fv; s_valid = 1'b1;
    a0 = u[0].acc; a1 = u[1].acc; a2 = u[2].acc;
    n = 0;
    while ((u[0].acc == a0 || u[1].acc == a1 || u[2].acc == a2) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 0, n < 8000, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(u[0].bus.tgt_ready && u[1].bus.tgt_ready && u[2].bus.tgt_ready) && n < 20000)
    begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 0, n < 20000, 1);
  endtask

  // High-time per period of instance 0 (PRESCALE=1), for consecutive periods.
  task automatic measure(input int nper);
    int n = 0;
    for (int j = 0; j < 16; j++) begin mr[j] = 0; mg[j] = 0; mb[j] = 0; end
    @(negedge clk);
    while (u[0].ps !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("period_timeout", 0, n < 1000, 1);
    for (int j = 0; j < nper; j++) begin
      repeat (256) begin
        @(negedge clk);
        mr[j] += int'(u[0].red);
        mg[j] += int'(u[0].green);
        mb[j] += int'(u[0].blue);
      end
    end
  endtask

  initial begin
    int exp_r3 [8] = '{0, 1, 1, 2, 2, 3, 3, 4};
    int exp_g3 [8] = '{0, 1, 1, 2, 2, 2, 2, 2};
    int exp_r4 [10] = '{255, 254, 254, 253, 253, 252, 252, 251, 251, 250};
    int n;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: all outputs low, ready high.
    repeat (1024) @(negedge clk);
    check("t1_ready", 0, u[0].bus.tgt_ready, 1);
    measure(1);
    check("t1_red_hi", 0, mr[0], 0);
    check("t1_blue_hi", 0, mb[0], 0);

    // Jump accepted mid-period.
    repeat (100) @(negedge clk);
    present(8'd128, 8'd0, 8'd255, 1'b0);
    s_valid = 1'b0;
    check("t2_busy", 0, u[0].busy, 1);
    wait_idle();
    measure(1);
    check("t2_red_hi", 0, mr[0], 128);
    check("t2_green_hi", 0, mg[0], 0);
    check("t2_blue_hi", 0, mb[0], 255);

    // Fade up from zero, one step every two periods.
    do_reset();
    repeat (100) @(negedge clk);
    present(8'd4, 8'd2, 8'd0, 1'b1);
    s_valid = 1'b0;
    measure(8);
    for (int j = 0; j < 8; j++) begin
      check("t3_red_hi", 0, mr[j], exp_r3[j]);
      check("t3_green_hi", 0, mg[j], exp_g3[j]);
      check("t3_blue_hi", 0, mb[j], 0);
    end
    check("t3_ready_after", 0, u[0].bus.tgt_ready, 1);
    wait_idle();

    // Fade down from full scale: never wraps, widths only shrink.
    present(8'd255, 8'd10, 8'd0, 1'b0);
    s_valid = 1'b0;
    wait_idle();
    present(8'd250, 8'd10, 8'd0, 1'b1);
    s_valid = 1'b0;
    measure(10);
    for (int j = 0; j < 10; j++) check("t4_red_hi", 0, mr[j], exp_r4[j]);
    wait_idle();

    // A different colour held during busy is taken only once ready returns.
    present(8'd252, 8'd12, 8'd3, 1'b1);
    check("t5_busy", 0, u[0].busy, 1);
    present(8'd7, 8'd7, 8'd7, 1'b0);
    s_valid = 1'b0;
    wait_idle();
    measure(1);
    check("t5_red_hi", 0, mr[0], 7);
    check("t5_green_hi", 0, mg[0], 7);
    check("t5_blue_hi", 0, mb[0], 7);

    // Reset in the middle of a fade, while red is driving high.
    do_reset();
    repeat (100) @(negedge clk);
    present(8'd4, 8'd0, 8'd0, 1'b1);
    s_valid = 1'b0;
    n = 0;
    while (u[0].d[0] != 3 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t6_timeout", 0, n < 5000, 1);
    @(negedge clk);
    check("t6_pre_red", 0, u[0].red, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_red", 0, u[0].red, 0);
    check("t6_async_busy", 0, u[0].busy, 0);
    check("t6_async_ready", 0, u[0].bus.tgt_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    measure(1);
    check("t6_red_hi", 0, mr[0], 0);
    check("t6_ready", 0, u[0].bus.tgt_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
